// File: rtl/mem_access_ctrl.sv
// Memory access sequencer between the core's IFU/LSU and the DPI memory bridge.
// Arbitrates requests, holds bridge inputs stable for LATENCY cycles, and returns one response pulse per request.
module mem_access_ctrl #(
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic        iClock,
  input  logic        iResetN,
  input  logic        iIfuReqValid,
  output logic        oIfuReqReady,
  input  logic [63:0] iIfuAddr,
  output logic        oIfuRespValid,
  output logic [63:0] oIfuRespData,
  input  logic        iLsuReqValid,
  output logic        oLsuReqReady,
  input  logic        iLsuWrEn,
  input  logic [63:0] iLsuAddr,
  input  logic [63:0] iLsuWrData,
  input  logic [7:0]  iLsuWrLen,
  output logic        oLsuRespValid,
  output logic [63:0] oLsuRespData,
  output logic [63:0] oMemRdAddrInst,
  output logic [63:0] oMemRdAddrLoad,
  output logic        oMemWrEn,
  output logic [63:0] oMemWrAddr,
  output logic [63:0] oMemWrData,
  output logic [7:0]  oMemWrLen,
  input  logic [63:0] iMemRdDataInst,
  input  logic [63:0] iMemRdDataLoad,
  output logic        oBusy
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] streak;
  logic [CW-1:0] cnt;
  logic          kind_lsu;
  logic          kind_wr;
  logic          grant_lsu;
  logic          grant_ifu;

  // Grant, readies and next state; readies exist only in IDLE and out of reset
  always_comb begin
    next_state   = state;
    grant_lsu    = 1'b0;
    grant_ifu    = 1'b0;
    oIfuReqReady = 1'b0;
    oLsuReqReady = 1'b0;
    case (state)
      IDLE: begin
        grant_lsu    = iLsuReqValid && (!iIfuReqValid || (streak < CW'(MAX_LSU_STREAK)));
        grant_ifu    = iIfuReqValid && !grant_lsu;
        oIfuReqReady = iResetN && grant_ifu;
        oLsuReqReady = iResetN && grant_lsu;
        if (oIfuReqReady || oLsuReqReady) next_state = ACCESS;
      end
      ACCESS: if (cnt == '0) next_state = RESP;
      RESP:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iResetN) state <= IDLE;
    else          state <= next_state;
  end

  // Bridge outputs change only on the edge after a handshake, so the bridge never sees spurious accesses
  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      streak         <= '0;
      cnt            <= '0;
      kind_lsu       <= 1'b0;
      kind_wr        <= 1'b0;
      oIfuRespValid  <= 1'b0;
      oIfuRespData   <= '0;
      oLsuRespValid  <= 1'b0;
      oLsuRespData   <= '0;
      oMemRdAddrInst <= '0;
      oMemRdAddrLoad <= '0;
      oMemWrEn       <= 1'b0;
      oMemWrAddr     <= '0;
      oMemWrData     <= '0;
      oMemWrLen      <= '0;
      oBusy          <= 1'b0;
    end else begin
      oMemWrEn      <= 1'b0;
      oIfuRespValid <= 1'b0;
      oLsuRespValid <= 1'b0;
      oBusy         <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (oIfuReqReady) begin
            kind_lsu       <= 1'b0;
            kind_wr        <= 1'b0;
            cnt            <= CW'(LATENCY - 1);
            streak         <= '0;
            oMemRdAddrInst <= iIfuAddr;
          end else if (oLsuReqReady) begin
            kind_lsu <= 1'b1;
            kind_wr  <= iLsuWrEn;
            cnt      <= CW'(LATENCY - 1);
            if (!iIfuReqValid)                         streak <= '0;
            else if (streak != CW'(MAX_LSU_STREAK))    streak <= streak + CW'(1);
            if (iLsuWrEn) begin
              oMemWrEn   <= 1'b1;
              oMemWrAddr <= iLsuAddr;
              oMemWrData <= iLsuWrData;
              oMemWrLen  <= iLsuWrLen;
            end else begin
              oMemRdAddrLoad <= iLsuAddr;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!kind_lsu) begin
              oIfuRespValid <= 1'b1;
              oIfuRespData  <= iMemRdDataInst;
            end else begin
              oLsuRespValid <= 1'b1;
              oLsuRespData  <= kind_wr ? 64'd0 : iMemRdDataLoad;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed requests push expected responses, a monitor pops and compares.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ifu_valid, ifu_ready, ifu_resp_valid;
  logic [63:0] ifu_addr, ifu_resp_data;
  logic        lsu_valid, lsu_ready, lsu_wr_en, lsu_resp_valid;
  logic [63:0] lsu_addr, lsu_wr_data, lsu_resp_data;
  logic [7:0]  lsu_wr_len;
  logic [63:0] rd_addr_inst, rd_addr_load, wr_addr, wr_data, rd_data_inst, rd_data_load;
  logic        mem_wr_en, busy;
  logic [7:0]  wr_len;

  logic        b_ifu_valid, b_ifu_ready, b_ifu_resp_valid, b_lsu_ready, b_lsu_resp_valid;
  logic        b_wr_en, b_busy;
  logic [63:0] b_ifu_addr, b_ifu_resp_data, b_lsu_resp_data, b_rd_addr_inst, b_rd_addr_load;
  logic [63:0] b_wr_addr, b_wr_data, b_rd_data_inst;
  logic [7:0]  b_wr_len;

  // Bridge models: fixed contents for the boot address, otherwise address-derived
  assign rd_data_inst   = (rd_addr_inst == 64'h8000_0000) ? 64'h0010_0073 : (rd_addr_inst ^ 64'hA5A5);
  assign rd_data_load   = rd_addr_load + 64'h5;
  assign b_rd_data_inst = b_rd_addr_inst ^ 64'hA5A5;

  mem_access_ctrl #(.LATENCY(2), .MAX_LSU_STREAK(4)) dut (
    .iClock(clk), .iResetN(rst_n),
    .iIfuReqValid(ifu_valid), .oIfuReqReady(ifu_ready), .iIfuAddr(ifu_addr),
    .oIfuRespValid(ifu_resp_valid), .oIfuRespData(ifu_resp_data),
    .iLsuReqValid(lsu_valid), .oLsuReqReady(lsu_ready), .iLsuWrEn(lsu_wr_en),
    .iLsuAddr(lsu_addr), .iLsuWrData(lsu_wr_data), .iLsuWrLen(lsu_wr_len),
    .oLsuRespValid(lsu_resp_valid), .oLsuRespData(lsu_resp_data),
    .oMemRdAddrInst(rd_addr_inst), .oMemRdAddrLoad(rd_addr_load),
    .oMemWrEn(mem_wr_en), .oMemWrAddr(wr_addr), .oMemWrData(wr_data), .oMemWrLen(wr_len),
    .iMemRdDataInst(rd_data_inst), .iMemRdDataLoad(rd_data_load), .oBusy(busy)
  );

  mem_access_ctrl #(.LATENCY(1), .MAX_LSU_STREAK(4)) dut1 (
    .iClock(clk), .iResetN(rst_n),
    .iIfuReqValid(b_ifu_valid), .oIfuReqReady(b_ifu_ready), .iIfuAddr(b_ifu_addr),
    .oIfuRespValid(b_ifu_resp_valid), .oIfuRespData(b_ifu_resp_data),
    .iLsuReqValid(1'b0), .oLsuReqReady(b_lsu_ready), .iLsuWrEn(1'b0),
    .iLsuAddr(64'd0), .iLsuWrData(64'd0), .iLsuWrLen(8'd0),
    .oLsuRespValid(b_lsu_resp_valid), .oLsuRespData(b_lsu_resp_data),
    .oMemRdAddrInst(b_rd_addr_inst), .oMemRdAddrLoad(b_rd_addr_load),
    .oMemWrEn(b_wr_en), .oMemWrAddr(b_wr_addr), .oMemWrData(b_wr_data), .oMemWrLen(b_wr_len),
    .iMemRdDataInst(b_rd_data_inst), .iMemRdDataLoad(64'd0), .oBusy(b_busy)
  );

  typedef struct packed { logic lsu; logic [63:0] data; } resp_t;
  typedef struct packed { logic [63:0] addr; logic [63:0] data; logic [7:0] len; } wr_t;

  resp_t q[$];
  resp_t q1[$];
  wr_t   wq[$];
  int    b_resp_cyc[$];
  int    tests = 0, fails = 0, cyc = 0;
  int    resp_cnt = 0, wr_cnt = 0, last_resp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a response or a bridge write
  always @(negedge clk) begin
    resp_t e;
    wr_t   w;
    if (rst_n) begin
      check("one_ready", 64'(ifu_ready & lsu_ready), 64'd0);
      if (busy) check("ready_in_busy", 64'(ifu_ready | lsu_ready), 64'd0);
      if (b_busy) check("b_ready_in_busy", 64'(b_ifu_ready), 64'd0);
      if (ifu_resp_valid || lsu_resp_valid) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: ifu=%0b lsu=%0b with no response expected", ifu_resp_valid, lsu_resp_valid);
        end else begin
          e = q.pop_front();
          check("resp_kind", 64'({ifu_resp_valid, lsu_resp_valid}), e.lsu ? 64'd1 : 64'd2);
          check("resp_data", e.lsu ? lsu_resp_data : ifu_resp_data, e.data);
        end
      end
      if (mem_wr_en) begin
        wr_cnt++;
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_wr: addr=%h with no write expected", wr_addr);
        end else begin
          w = wq.pop_front();
          check("wr_addr", wr_addr, w.addr);
          check("wr_data", wr_data, w.data);
          check("wr_len", 64'(wr_len), 64'(w.len));
        end
      end
      if (b_ifu_resp_valid || b_lsu_resp_valid) begin
        b_resp_cyc.push_back(cyc);
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected_resp: ifu=%0b lsu=%0b", b_ifu_resp_valid, b_lsu_resp_valid);
        end else begin
          e = q1.pop_front();
          check("b_resp_lsu", 64'(b_lsu_resp_valid), 64'd0);
          check("b_resp_data", b_ifu_resp_data, e.data);
        end
      end
    end
  end

  // Waits (bounded) for the chosen ready, then steps through the handshake edge; h1 = cycle after handshake
  task automatic wait_ready(input bit lsu, output int h1);
    int n = 0;
    while (!(lsu ? lsu_ready : ifu_ready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL ready_timeout: lsu=%0b no ready within 50 cycles", lsu);
    end
    @(posedge clk); #1;
    h1 = cyc;
    ifu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  task automatic issue_ifu(input logic [63:0] addr, input logic [63:0] exp, output int h1);
    q.push_back('{lsu: 1'b0, data: exp});
    @(negedge clk);
    ifu_addr  = addr;
    ifu_valid = 1'b1;
    #1;
    wait_ready(1'b0, h1);
  endtask

  task automatic issue_lsu(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] len, input logic [63:0] exp, input bit expect_resp,
                           output int h1);
    if (expect_resp) q.push_back('{lsu: 1'b1, data: exp});
    if (wr) wq.push_back('{addr: addr, data: data, len: len});
    @(negedge clk);
    lsu_wr_en   = wr;
    lsu_addr    = addr;
    lsu_wr_data = data;
    lsu_wr_len  = len;
    lsu_valid   = 1'b1;
    #1;
    wait_ready(1'b1, h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1, prev, prevw, n;
    logic [9:0] exp_seq;
    logic       g;
    rst_n = 1'b0;
    ifu_valid = 1'b1; ifu_addr = '0;
    lsu_valid = 1'b0; lsu_wr_en = 1'b0; lsu_addr = '0; lsu_wr_data = '0; lsu_wr_len = '0;
    b_ifu_valid = 1'b0; b_ifu_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ifu_ready", 64'(ifu_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_rd_addr_inst", rd_addr_inst, 64'd0);
    ifu_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // IFU-only fetch: address at H+1, response exactly at H+3, busy H+1..H+3
    prev = resp_cnt;
    issue_ifu(64'h8000_0000, 64'h0010_0073, h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) check("fetch_addr", rd_addr_inst, 64'h8000_0000);
      check("fetch_busy", 64'(busy), (k < 3) ? 64'd1 : 64'd0);
    end
    check("fetch_resp_count", 64'(resp_cnt - prev), 64'd1);
    check("fetch_resp_cycle", 64'(last_resp_cyc - h1), 64'd2);

    // Store: one write pulse, zero response data, write bus holds afterwards
    prev = resp_cnt; prevw = wr_cnt;
    issue_lsu(1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'd4, 64'd0, 1'b1, h1);
    repeat (4) @(negedge clk);
    check("store_resp_count", 64'(resp_cnt - prev), 64'd1);
    check("store_wr_count", 64'(wr_cnt - prevw), 64'd1);
    check("store_addr_hold", wr_addr, 64'h8000_1000);
    check("store_wr_en_low", 64'(mem_wr_en), 64'd0);

    // Load then fetch: load address stays put during the fetch
    prev = resp_cnt;
    issue_lsu(1'b0, 64'h8000_2000, 64'd0, 8'd0, 64'h8000_2005, 1'b1, h1);
    repeat (4) @(negedge clk);
    issue_ifu(64'h8000_0040, 64'h8000_A5E5, h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("load_addr_hold", rd_addr_load, 64'h8000_2000);
    end
    @(negedge clk);
    check("load_fetch_count", 64'(resp_cnt - prev), 64'd2);

    // Both requesters held valid: LSU streak of 4, then IFU is forced
    prev = resp_cnt;
    exp_seq = 10'b11110_11110;
    @(negedge clk);
    ifu_addr = 64'h8000_0000; lsu_addr = 64'h8000_2000; lsu_wr_en = 1'b0;
    ifu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (!(ifu_ready || lsu_ready) && n < 50) begin
        @(negedge clk); #1; n++;
      end
      g = lsu_ready;
      q.push_back(g ? '{lsu: 1'b1, data: 64'h8000_2005} : '{lsu: 1'b0, data: 64'h0010_0073});
      check("grant_seq", 64'(g), 64'(exp_seq[9-i]));
      @(posedge clk); #1;
    end
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("streak_resp_count", 64'(resp_cnt - prev), 64'd10);

    // Reset during ACCESS of a store: no later write or response, everything cleared
    prev = resp_cnt; prevw = wr_cnt;
    issue_lsu(1'b1, 64'h8000_3000, 64'h1234, 8'd8, 64'd0, 1'b0, h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("mid_rst_wr_addr", wr_addr, 64'd0);
    check("mid_rst_rd_addr_load", rd_addr_load, 64'd0);
    check("mid_rst_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_no_resp", 64'(resp_cnt - prev), 64'd0);
    check("mid_rst_one_wr", 64'(wr_cnt - prevw), 64'd1);

    // LATENCY=1 instance: back-to-back fetches respond every 3 cycles
    b_ifu_addr = 64'h8000_0100;
    repeat (3) q1.push_back('{lsu: 1'b0, data: 64'h8000_A4A5});
    b_ifu_valid = 1'b1;
    n = 0;
    while (b_resp_cyc.size() < 3 && n < 30) begin
      @(negedge clk); #1; n++;
    end
    b_ifu_valid = 1'b0;
    check("b_resp_count", 64'(b_resp_cyc.size()), 64'd3);
    if (b_resp_cyc.size() >= 3) begin
      check("b_resp_gap0", 64'(b_resp_cyc[1] - b_resp_cyc[0]), 64'd3);
      check("b_resp_gap1", 64'(b_resp_cyc[2] - b_resp_cyc[1]), 64'd3);
    end
    repeat (4) @(negedge clk);
    check("sb_empty", 64'(q.size() + q1.size() + wq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
